// File: rtl/id_stage.sv
// id_stage: LA32R instruction-decode stage.
// Buffers fetched {pc, inst} pairs in a circular FIFO, decodes the head entry
// combinationally, issues it to EX and resolves branches/jumps on issue.
// Optional feature macro: ID_PERF_CNT_EN adds the perf_issue_cnt/perf_stall_cnt counters.
module id_stage #(
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_to_id_valid,
  input  logic [31:0] if_to_id_pc,
  input  logic [31:0] if_to_id_inst,
  output logic        o_id_ready,
  output logic        id_to_ex_valid,
  input  logic        i_ex_ready,
  input  logic        hazard_stall,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [31:0] id_to_ex_pc,
  output logic [31:0] id_to_ex_inst,
  output logic [31:0] id_to_ex_src1,
  output logic [31:0] id_to_ex_src2,
  output logic [31:0] id_to_ex_mem_wdata,
  output logic [15:0] id_to_ex_alu_op,
`ifdef ID_PERF_CNT_EN
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [4:0]  id_to_ex_rf_waddr
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_entry_t;

  ibuf_entry_t      ibuf_q [IBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic        empty, full, push, fire, head_vld;
  ibuf_entry_t head;
  logic [31:0] inst;

  logic is_add_w, is_sub_w, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
  logic is_slli_w, is_srli_w, is_srai_w, is_addi_w, is_ld_w, is_st_w;
  logic is_jirl, is_b, is_bl, is_beq, is_bne, is_lu12i_w;
  logic is_shift_imm, is_si12_imm, is_link, writes_gr, br_cond;

  logic [4:0]  rd, rj, rk, dest;
  logic [31:0] offs16_ext, offs26_ext, si12_ext, ui5_ext, si20_ext;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(IBUF_DEPTH));
  assign head_vld = ~empty;
  assign head     = ibuf_q[rd_ptr_q];
  assign inst     = head.inst;

  assign o_id_ready     = ~full;
  assign id_to_ex_valid = head_vld & ~hazard_stall;
  assign fire           = id_to_ex_valid & i_ex_ready;
  // A taken branch flushes the buffer, so a same-cycle push is dropped.
  assign push           = if_to_id_valid & o_id_ready & ~br_taken;

  // Instruction fields
  assign rd         = inst[4:0];
  assign rj         = inst[9:5];
  assign rk         = inst[14:10];
  assign offs16_ext = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26_ext = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign si12_ext   = {{20{inst[21]}}, inst[21:10]};
  assign ui5_ext    = {27'd0, inst[14:10]};
  assign si20_ext   = {inst[24:5], 12'd0};

  // Opcode match; every flag is forced low while the buffer is empty
  assign is_add_w   = head_vld && (inst[31:15] == 17'h00020);
  assign is_sub_w   = head_vld && (inst[31:15] == 17'h00022);
  assign is_slt     = head_vld && (inst[31:15] == 17'h00024);
  assign is_sltu    = head_vld && (inst[31:15] == 17'h00025);
  assign is_nor     = head_vld && (inst[31:15] == 17'h00028);
  assign is_and     = head_vld && (inst[31:15] == 17'h00029);
  assign is_or      = head_vld && (inst[31:15] == 17'h0002a);
  assign is_xor     = head_vld && (inst[31:15] == 17'h0002b);
  assign is_slli_w  = head_vld && (inst[31:15] == 17'h00081);
  assign is_srli_w  = head_vld && (inst[31:15] == 17'h00089);
  assign is_srai_w  = head_vld && (inst[31:15] == 17'h00091);
  assign is_addi_w  = head_vld && (inst[31:22] == 10'h00a);
  assign is_ld_w    = head_vld && (inst[31:22] == 10'h0a2);
  assign is_st_w    = head_vld && (inst[31:22] == 10'h0a6);
  assign is_lu12i_w = head_vld && (inst[31:25] == 7'h0a);
  assign is_jirl    = head_vld && (inst[31:26] == 6'h13);
  assign is_b       = head_vld && (inst[31:26] == 6'h14);
  assign is_bl      = head_vld && (inst[31:26] == 6'h15);
  assign is_beq     = head_vld && (inst[31:26] == 6'h16);
  assign is_bne     = head_vld && (inst[31:26] == 6'h17);

  assign is_shift_imm = is_slli_w | is_srli_w | is_srai_w;
  assign is_si12_imm  = is_addi_w | is_ld_w | is_st_w;
  assign is_link      = is_jirl | is_bl;
  assign dest         = is_bl ? 5'd1 : rd;
  assign writes_gr    = is_add_w | is_sub_w | is_slt | is_sltu | is_nor | is_and |
                        is_or | is_xor | is_shift_imm | is_addi_w | is_ld_w |
                        is_link | is_lu12i_w;
  assign br_cond      = is_b | is_bl | is_jirl |
                        (is_beq & (rf_rdata1 == rf_rdata2)) |
                        (is_bne & (rf_rdata1 != rf_rdata2));

  // Decode of the head entry into EX payload, register reads and redirect
  always_comb begin
    id_to_ex_alu_op    = '0;
    rf_raddr1          = '0;
    rf_raddr2          = '0;
    id_to_ex_src1      = rf_rdata1;
    id_to_ex_src2      = rf_rdata2;
    id_to_ex_mem_wdata = '0;
    id_to_ex_rf_waddr  = '0;
    br_target          = head.pc + offs16_ext;

    id_to_ex_pc   = head.pc;
    id_to_ex_inst = head.inst;

    id_to_ex_alu_op[0]  = is_add_w | is_addi_w | is_ld_w | is_st_w | is_link;
    id_to_ex_alu_op[1]  = is_sub_w;
    id_to_ex_alu_op[2]  = is_slt;
    id_to_ex_alu_op[3]  = is_sltu;
    id_to_ex_alu_op[4]  = is_and;
    id_to_ex_alu_op[5]  = is_nor;
    id_to_ex_alu_op[6]  = is_or;
    id_to_ex_alu_op[7]  = is_xor;
    id_to_ex_alu_op[8]  = is_slli_w;
    id_to_ex_alu_op[9]  = is_srli_w;
    id_to_ex_alu_op[10] = is_srai_w;
    id_to_ex_alu_op[11] = is_lu12i_w;
    id_to_ex_alu_op[12] = is_st_w;
    id_to_ex_alu_op[13] = writes_gr & (dest != 5'd0);
    id_to_ex_alu_op[14] = is_ld_w;

    if (head_vld) begin
      rf_raddr1         = rj;
      id_to_ex_rf_waddr = dest;
      if (is_beq | is_bne | is_st_w)
        rf_raddr2 = rd;
      else if (is_shift_imm | is_si12_imm | is_lu12i_w | is_link | is_b)
        rf_raddr2 = '0;
      else
        rf_raddr2 = rk;
    end

    if (is_link)
      id_to_ex_src1 = head.pc;

    if (is_link)
      id_to_ex_src2 = 32'd4;
    else if (is_lu12i_w)
      id_to_ex_src2 = si20_ext;
    else if (is_shift_imm)
      id_to_ex_src2 = ui5_ext;
    else if (is_si12_imm)
      id_to_ex_src2 = si12_ext;

    if (is_st_w)
      id_to_ex_mem_wdata = rf_rdata2;

    if (is_jirl)
      br_target = rf_rdata1 + offs16_ext;
    else if (is_b | is_bl)
      br_target = head.pc + offs26_ext;
  end

  assign br_taken = fire & br_cond;

  // Buffer pointers and occupancy; a taken branch empties the buffer
  always_ff @(posedge clk) begin
    if (rst || br_taken) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fire)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !fire)
        count_q <= count_q + CNT_W'(1);
      else if (fire && !push)
        count_q <= count_q - CNT_W'(1);
    end
  end

  // Buffer storage; data needs no reset since occupancy qualifies it
  always_ff @(posedge clk) begin
    if (push)
      ibuf_q[wr_ptr_q] <= '{pc: if_to_id_pc, inst: if_to_id_inst};
  end

`ifdef ID_PERF_CNT_EN
  // Issue and stall counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fire)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (head_vld && !fire)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: scoreboard of expected issues plus directed scenario tasks.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc, if_to_id_inst;
  logic        o_id_ready, id_to_ex_valid, i_ex_ready, hazard_stall;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        br_taken;
  logic [31:0] br_target, id_to_ex_pc, id_to_ex_inst, id_to_ex_src1, id_to_ex_src2;
  logic [31:0] id_to_ex_mem_wdata;
  logic [15:0] id_to_ex_alu_op;
  logic [4:0]  id_to_ex_rf_waddr;
`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  id_stage #(.IBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .if_to_id_valid(if_to_id_valid), .if_to_id_pc(if_to_id_pc), .if_to_id_inst(if_to_id_inst),
    .o_id_ready(o_id_ready), .id_to_ex_valid(id_to_ex_valid), .i_ex_ready(i_ex_ready),
    .hazard_stall(hazard_stall),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .br_taken(br_taken), .br_target(br_target),
    .id_to_ex_pc(id_to_ex_pc), .id_to_ex_inst(id_to_ex_inst),
    .id_to_ex_src1(id_to_ex_src1), .id_to_ex_src2(id_to_ex_src2),
    .id_to_ex_mem_wdata(id_to_ex_mem_wdata), .id_to_ex_alu_op(id_to_ex_alu_op),
`ifdef ID_PERF_CNT_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .id_to_ex_rf_waddr(id_to_ex_rf_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] alu;
    logic [4:0]  wa;
    logic        chk_wa;
    logic        br;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [15:0] alu, input logic [4:0] wa,
                              input logic chk_wa, input logic br, input logic [31:0] tgt);
    exp_t e;
    e.pc = pc; e.inst = inst; e.alu = alu; e.wa = wa;
    e.chk_wa = chk_wa; e.br = br; e.tgt = tgt;
    return e;
  endfunction

  // Issue monitor: every fire must match the oldest expected entry in order
  always @(negedge clk) begin
    if (!rst && id_to_ex_valid && i_ex_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL issue_unexpected: pc=%h inst=%h issued, none expected", id_to_ex_pc, id_to_ex_inst);
      end else begin
        mon_e = sb.pop_front();
        if (id_to_ex_pc !== mon_e.pc || id_to_ex_inst !== mon_e.inst ||
            id_to_ex_alu_op !== mon_e.alu || (mon_e.chk_wa && id_to_ex_rf_waddr !== mon_e.wa) ||
            br_taken !== mon_e.br || (mon_e.br && br_target !== mon_e.tgt)) begin
          tests_failed++;
          $display("FAIL issue_match: got pc=%h inst=%h alu=%h wa=%0d br=%b tgt=%h want pc=%h inst=%h alu=%h wa=%0d br=%b tgt=%h",
                   id_to_ex_pc, id_to_ex_inst, id_to_ex_alu_op, id_to_ex_rf_waddr, br_taken, br_target,
                   mon_e.pc, mon_e.inst, mon_e.alu, mon_e.wa, mon_e.br, mon_e.tgt);
        end
        if (mon_e.br) sb.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain_timeout: %0d entries left, want 0", name, sb.size());
    end
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b0 || o_id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_empty: valid=%b ready=%b want valid=0 ready=1", name, id_to_ex_valid, o_id_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_to_id_valid = 1'b0; if_to_id_pc = '0; if_to_id_inst = '0;
    i_ex_ready = 1'b0; hazard_stall = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_id_ready !== 1'b1 || id_to_ex_valid !== 1'b0 || br_taken !== 1'b0 ||
        rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0 || id_to_ex_alu_op !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b br=%b ra1=%0d ra2=%0d alu=%h want 1 0 0 0 0 0000",
               o_id_ready, id_to_ex_valid, br_taken, rf_raddr1, rf_raddr2, id_to_ex_alu_op);
    end
  endtask

  task automatic test_add();
    step();
    i_ex_ready = 1'b1; rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h100; if_to_id_inst = 32'h00100823;
    sb.push_back(mk(32'h100, 32'h00100823, 16'h2001, 5'd3, 1'b1, 1'b0, 32'h0));
    step();
    if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b1 || id_to_ex_src1 !== 32'd5 || id_to_ex_src2 !== 32'd7 ||
        id_to_ex_alu_op !== 16'h2001 || id_to_ex_rf_waddr !== 5'd3) begin
      tests_failed++;
      $display("FAIL add_decode: valid=%b src1=%0d src2=%0d alu=%h wa=%0d want 1 5 7 2001 3",
               id_to_ex_valid, id_to_ex_src1, id_to_ex_src2, id_to_ex_alu_op, id_to_ex_rf_waddr);
    end
    tests_run++;
    if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
      tests_failed++;
      $display("FAIL add_raddr: ra1=%0d ra2=%0d want 1 2", rf_raddr1, rf_raddr2);
    end
    drain("add");
  endtask

  task automatic test_full();
    logic [31:0] insts [4];
    logic [15:0] alus  [4];
    logic [4:0]  was   [4];
    insts[0] = 32'h001118A4; alus[0] = 16'h2002; was[0] = 5'd4;  // sub.w r4,r5,r6
    insts[1] = 32'h00120827; alus[1] = 16'h2004; was[1] = 5'd7;  // slt r7,r1,r2
    insts[2] = 32'h00150820; alus[2] = 16'h0040; was[2] = 5'd0;  // or r0,r1,r2
    insts[3] = 32'h142468A5; alus[3] = 16'h2800; was[3] = 5'd5;  // lu12i.w r5,0x12345
    step();
    i_ex_ready = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    for (int i = 0; i < 4; i++) begin
      if_to_id_valid = 1'b1; if_to_id_pc = 32'h200 + 32'(4 * i); if_to_id_inst = insts[i];
      sb.push_back(mk(32'h200 + 32'(4 * i), insts[i], alus[i], was[i], 1'b1, 1'b0, 32'h0));
      step();
    end
    if_to_id_pc = 32'h300; if_to_id_inst = 32'h00100823;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if (o_id_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_ready_%0d: ready=%b want 0", k, o_id_ready);
      end
      step();
    end
    if_to_id_valid = 1'b0; i_ex_ready = 1'b1;
    drain("full");
  endtask

  task automatic test_branch();
    step();
    i_ex_ready = 1'b0; rf_rdata1 = 32'd9; rf_rdata2 = 32'd9;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h1000; if_to_id_inst = 32'h58001022;  // beq r1,r2,+16
    sb.push_back(mk(32'h1000, 32'h58001022, 16'h0, 5'd0, 1'b0, 1'b1, 32'h1010));
    step();
    if_to_id_pc = 32'h1004; if_to_id_inst = 32'h00100823;
    sb.push_back(mk(32'h1004, 32'h00100823, 16'h2001, 5'd3, 1'b1, 1'b0, 32'h0));
    step();
    if_to_id_pc = 32'h1008; if_to_id_inst = 32'h00100824;
    sb.push_back(mk(32'h1008, 32'h00100824, 16'h2001, 5'd4, 1'b1, 1'b0, 32'h0));
    step();
    if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (br_taken !== 1'b0 || rf_raddr2 !== 5'd2 || br_target !== 32'h1010) begin
      tests_failed++;
      $display("FAIL beq_stalled: br=%b ra2=%0d tgt=%h want 0 2 00001010", br_taken, rf_raddr2, br_target);
    end
    step();
    i_ex_ready = 1'b1; if_to_id_valid = 1'b1; if_to_id_pc = 32'h3000; if_to_id_inst = 32'h00100823;
    @(negedge clk);
    tests_run++;
    if (br_taken !== 1'b1 || br_target !== 32'h1010) begin
      tests_failed++;
      $display("FAIL beq_taken: br=%b tgt=%h want 1 00001010", br_taken, br_target);
    end
    step();
    if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b0 || o_id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL beq_flush: valid=%b ready=%b want 0 1", id_to_ex_valid, o_id_ready);
    end
    // bne with equal operands falls through to the younger entry
    step();
    i_ex_ready = 1'b0;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h1100; if_to_id_inst = 32'h5C001022;
    sb.push_back(mk(32'h1100, 32'h5C001022, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    step();
    if_to_id_pc = 32'h1104; if_to_id_inst = 32'h00100823;
    sb.push_back(mk(32'h1104, 32'h00100823, 16'h2001, 5'd3, 1'b1, 1'b0, 32'h0));
    step();
    if_to_id_valid = 1'b0; i_ex_ready = 1'b1;
    drain("bne");
    // bl with offs26 = -1 links through r1 and jumps back one word
    step();
    i_ex_ready = 1'b0;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h2000; if_to_id_inst = 32'h57FFFFFF;
    sb.push_back(mk(32'h2000, 32'h57FFFFFF, 16'h2001, 5'd1, 1'b1, 1'b1, 32'h1FFC));
    step();
    if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_src1 !== 32'h2000 || id_to_ex_src2 !== 32'd4 || id_to_ex_rf_waddr !== 5'd1 ||
        br_target !== 32'h1FFC) begin
      tests_failed++;
      $display("FAIL bl_decode: src1=%h src2=%0d wa=%0d tgt=%h want 00002000 4 1 00001ffc",
               id_to_ex_src1, id_to_ex_src2, id_to_ex_rf_waddr, br_target);
    end
    step();
    i_ex_ready = 1'b1;
    drain("bl");
  endtask

  task automatic test_hazard();
    step();
    rst = 1'b1; if_to_id_valid = 1'b0; hazard_stall = 1'b0; i_ex_ready = 1'b1;
    rf_rdata1 = 32'h40; rf_rdata2 = '0;
    sb.delete();
    step();
    rst = 1'b0; hazard_stall = 1'b1;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h400; if_to_id_inst = 32'h28802024;  // ld.w r4,8(r1)
    sb.push_back(mk(32'h400, 32'h28802024, 16'h6001, 5'd4, 1'b1, 1'b0, 32'h0));
`ifdef ID_PERF_CNT_EN
    @(negedge clk);
    tests_run++;
    if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_reset: issue=%0d stall=%0d want 0 0", perf_issue_cnt, perf_stall_cnt);
    end
`endif
    step();
    if_to_id_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (id_to_ex_valid !== 1'b0 || id_to_ex_alu_op !== 16'h6001 || id_to_ex_src2 !== 32'd8 ||
          id_to_ex_rf_waddr !== 5'd4 || id_to_ex_pc !== 32'h400) begin
        tests_failed++;
        $display("FAIL hazard_hold_%0d: valid=%b alu=%h src2=%0d wa=%0d pc=%h want 0 6001 8 4 00000400",
                 k, id_to_ex_valid, id_to_ex_alu_op, id_to_ex_src2, id_to_ex_rf_waddr, id_to_ex_pc);
      end
      step();
    end
    hazard_stall = 1'b0;
    step();
`ifdef ID_PERF_CNT_EN
    @(negedge clk);
    tests_run++;
    if (perf_issue_cnt !== 32'd1 || perf_stall_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_counts: issue=%0d stall=%0d want 1 3", perf_issue_cnt, perf_stall_cnt);
    end
`endif
    drain("hazard");
  endtask

  task automatic test_store_unknown();
    step();
    i_ex_ready = 1'b0; rf_rdata1 = 32'h100; rf_rdata2 = 32'h55;
    if_to_id_valid = 1'b1; if_to_id_pc = 32'h500; if_to_id_inst = 32'h29803020;  // st.w r0,12(r1)
    sb.push_back(mk(32'h500, 32'h29803020, 16'h1001, 5'd0, 1'b1, 1'b0, 32'h0));
    step();
    if_to_id_pc = 32'h504; if_to_id_inst = 32'hFFFFFFFF;
    sb.push_back(mk(32'h504, 32'hFFFFFFFF, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0));
    step();
    if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_alu_op !== 16'h1001 || id_to_ex_mem_wdata !== 32'h55 || rf_raddr2 !== 5'd0 ||
        id_to_ex_src2 !== 32'd12) begin
      tests_failed++;
      $display("FAIL store_decode: alu=%h wdata=%h ra2=%0d src2=%0d want 1001 00000055 0 12",
               id_to_ex_alu_op, id_to_ex_mem_wdata, rf_raddr2, id_to_ex_src2);
    end
    step();
    i_ex_ready = 1'b1;
    step();
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b1 || id_to_ex_alu_op !== 16'h0 || id_to_ex_mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL unknown_nop: valid=%b alu=%h wdata=%h want 1 0000 00000000",
               id_to_ex_valid, id_to_ex_alu_op, id_to_ex_mem_wdata);
    end
    drain("unknown");
  endtask

  task automatic test_reset_mid();
    step();
    i_ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_to_id_valid = 1'b1; if_to_id_pc = 32'h700 + 32'(4 * i); if_to_id_inst = 32'h00100823;
      step();
    end
    if_to_id_pc = 32'h70C; rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0; if_to_id_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b0 || o_id_ready !== 1'b1 || rf_raddr1 !== 5'd0 || id_to_ex_alu_op !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b ready=%b ra1=%0d alu=%h want 0 1 0 0000",
               id_to_ex_valid, o_id_ready, rf_raddr1, id_to_ex_alu_op);
    end
    step();
    i_ex_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (id_to_ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_issue: valid=%b want 0", id_to_ex_valid);
    end
  endtask

  task automatic test_back_to_back();
    step();
    i_ex_ready = 1'b1; hazard_stall = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    for (int i = 0; i < 8; i++) begin
      if_to_id_valid = 1'b1; if_to_id_pc = 32'h600 + 32'(4 * i);
      if_to_id_inst = 32'h00100820 | 32'(i + 1);
      sb.push_back(mk(32'h600 + 32'(4 * i), 32'h00100820 | 32'(i + 1), 16'h2001, 5'(i + 1),
                      1'b1, 1'b0, 32'h0));
      @(negedge clk);
      tests_run++;
      if (o_id_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready_%0d: ready=%b want 1", i, o_id_ready);
      end
      step();
    end
    if_to_id_valid = 1'b0;
    drain("b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_full();
    test_branch();
    test_hazard();
    test_store_unknown();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter IBUF_DEPTH, default 4, instruction-buffer entries; SHALL be a power of two in 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_to_id_valid  in  1  IF offers {pc, inst} this cycle.
REQ-005 if_to_id_pc / if_to_id_inst  in  32 / 32  offered fetch pair.
REQ-006 o_id_ready  out  1  buffer can accept; SHALL equal ~full (no combinational path from i_ex_ready).
REQ-007 id_to_ex_valid  out  1  decoded head instruction offered to EX.
REQ-008 i_ex_ready  in  1  EX accepts this cycle.
REQ-009 hazard_stall  in  1  external interlock (e.g. load-use); blocks issue.
REQ-010 rf_raddr1 / rf_raddr2  out  5 / 5  register-file read addresses; rf_rdata1 / rf_rdata2  in  32 / 32  same-cycle read data.
REQ-011 br_taken  out  1  redirect pulse; br_target  out  32  redirect PC.
REQ-012 id_to_ex_pc / id_to_ex_inst / id_to_ex_src1 / id_to_ex_src2 / id_to_ex_mem_wdata  out  32 each.
REQ-013 id_to_ex_alu_op  out  16; id_to_ex_rf_waddr  out  5.
REQ-014 perf_issue_cnt / perf_stall_cnt  out  32 / 32  (present only with ID_PERF_CNT_EN).

Function
REQ-015 Buffer SHALL be a circular FIFO of IBUF_DEPTH {pc, inst} entries with rd/wr pointers and an occupancy count 0..IBUF_DEPTH.
REQ-016 push = if_to_id_valid & o_id_ready; fire = id_to_ex_valid & i_ex_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-017 Minimum latency: entry pushed at edge N SHALL be presented to EX in cycle N+1.
REQ-018 id_to_ex_valid = ~empty & ~hazard_stall; all decode outputs SHALL derive combinationally from the head entry.
REQ-019 Decoded set: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, ld.w, st.w, jirl, b, bl, beq, bne, lu12i.w (LA32R encodings); unknown opcode SHALL decode as a no-op (alu_op all zero).
REQ-020 alu_op map: [0] add (add.w, addi.w, ld.w, st.w, jirl, bl), [1] sub, [2] slt, [3] sltu, [4] and, [5] nor, [6] or, [7] xor, [8] sll, [9] srl, [10] sra, [11] lui, [12] mem_we, [13] gr_we, [14] res_from_mem, [15] 0; bits 12-14 SHALL be gated by ~empty.
REQ-021 gr_we SHALL be 0 for st.w, b, beq, bne and when dest = r0; bl dest SHALL be r1.
REQ-022 src1 = pc for jirl/bl else rf_rdata1; src2 = 4 for jirl/bl, {si20,12'b0} for lu12i.w, zero-extended ui5 for shifts, sign-extended si12 otherwise-immediate, else rf_rdata2.
REQ-023 rf_raddr2 = rd for beq/bne/st.w, 0 for immediate forms, else rk; both addresses SHALL be 0 when empty.
REQ-024 mem_wdata = rf_rdata2 for st.w, else 0.
REQ-025 br_taken SHALL assert only in a fire cycle for b, bl, jirl, beq (rj==rd), bne (rj!=rd); target = pc+offs26/offs16 (<<2, sign-extended) or rj+offs16<<2 for jirl.
REQ-026 On br_taken the branch SHALL dequeue, all younger entries SHALL be discarded and any same-cycle push SHALL be dropped; count = 0 after the edge.
REQ-027 hazard_stall or ~i_ex_ready SHALL hold the head and all outputs stable; branches SHALL NOT redirect while stalled.
REQ-028 Full: o_id_ready = 0; a same-cycle pop SHALL NOT admit a push that cycle.

Reset
REQ-029 rst SHALL clear pointers and count; o_id_ready = 1, id_to_ex_valid = 0, br_taken = 0, rf_raddr1/2 = 0, alu_op = 0 after the edge.
REQ-030 rst mid-operation SHALL discard all buffered entries regardless of push/fire that cycle.

Configuration
REQ-031 With ID_PERF_CNT_EN defined: perf_issue_cnt SHALL increment on fire; perf_stall_cnt SHALL increment when ~empty & ~fire; both reset to 0 and wrap at 2^32.
REQ-032 Without ID_PERF_CNT_EN: perf ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, then push add.w r3,r1,r2 (0x00100823) with rdata 5/7, i_ex_ready=1 -> next cycle valid=1, src1=5, src2=7, alu_op=0x2001, waddr=3.
REQ-034 i_ex_ready=0, push 4 entries (DEPTH=4) -> o_id_ready=0 after 4th push; 5th offered pair not accepted; release -> 4 fires in program order.
REQ-035 beq at pc 0x1000, offs16=4, rdata1=rdata2=9, two younger entries queued -> br_taken=1, br_target=0x1010, count=0 next cycle.
REQ-036 hazard_stall=1 for 3 cycles on head ld.w -> id_to_ex_valid=0, outputs stable; perf_stall_cnt +3 (macro on).
REQ-037 rst asserted with 3 entries and push active -> next cycle empty, o_id_ready=1, id_to_ex_valid=0.
REQ-038 Push st.w with rd=r0 and unknown opcode 0xFFFFFFFF -> st.w: alu_op[12]=1, [13]=0; unknown: alu_op=0, fires as no-op.
